alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq_pkg.sv | 18 +
 rtl/alu_seq_alu.sv | 23 ++
 rtl/alu_seq.sv | 91 +++++++++
 tb/tb_alu_seq.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequenced ALU: data width, opcodes and FSM states.
package alu_seq_pkg;

    localparam int DATA_W = 4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_alu.sv
// Combinational 4-bit ALU; arithmetic wraps modulo 2^DATA_W, unused opcodes give 0.
module alu_seq_alu
    import alu_seq_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        op,
    output logic [DATA_W-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NOT:  y = ~a;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// One-command-in-flight sequencer around the ALU: latch operands, execute,
// write back to the register file and hand the result off to a consumer.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter  int NREG  = 4,
    parameter  int CNT_W = 8,
    localparam int RW    = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [RW-1:0]     cmd_srca,
    input  logic [RW-1:0]     cmd_srcb,
    input  logic [RW-1:0]     cmd_dst,
    input  logic              cmd_imm_en,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [RW-1:0]     res_dst,
    output logic              res_zero,
    output logic [CNT_W-1:0]  op_count
);

    state_t            state;
    logic [DATA_W-1:0] rf [NREG];
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    logic [2:0]        op_q;
    logic [RW-1:0]     dst_q;
    logic [DATA_W-1:0] alu_y;

    alu_seq_alu u_alu (
        .a  (opa),
        .b  (opb),
        .op (op_q),
        .y  (alu_y)
    );

    // Handshake flags decode straight from the state register.
    assign cmd_ready = (state == ST_IDLE);
    assign res_valid = (state == ST_OUT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            opa      <= '0;
            opb      <= '0;
            op_q     <= '0;
            dst_q    <= '0;
            res_data <= '0;
            res_dst  <= '0;
            res_zero <= 1'b1;
            op_count <= '0;
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_q  <= cmd_op;
                        dst_q <= cmd_dst;
                        opa   <= rf[cmd_srca];
                        opb   <= cmd_imm_en ? cmd_imm : rf[cmd_srcb];
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // Operands were captured in IDLE, so aliased dst cannot disturb them.
                    res_data    <= alu_y;
                    res_dst     <= dst_q;
                    res_zero    <= (alu_y == '0);
                    rf[dst_q]   <= alu_y;
                    state       <= ST_OUT;
                end
                ST_OUT: begin
                    if (res_ready) begin
                        op_count <= op_count + 1'b1;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed scenarios plus randomized commands checked
// against an arithmetic model of the register file and completion counter.
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int NREG  = 4;
    localparam int CNT_W = 8;
    localparam int RW    = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [2:0]        cmd_op = '0;
    logic [RW-1:0]     cmd_srca = '0;
    logic [RW-1:0]     cmd_srcb = '0;
    logic [RW-1:0]     cmd_dst = '0;
    logic              cmd_imm_en = 1'b0;
    logic [DATA_W-1:0] cmd_imm = '0;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic [DATA_W-1:0] res_data;
    logic [RW-1:0]     res_dst;
    logic              res_zero;
    logic [CNT_W-1:0]  op_count;

    alu_seq #(.NREG(NREG), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_srca   (cmd_srca),
        .cmd_srcb   (cmd_srcb),
        .cmd_dst    (cmd_dst),
        .cmd_imm_en (cmd_imm_en),
        .cmd_imm    (cmd_imm),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_dst    (res_dst),
        .res_zero   (res_zero),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    int passes = 0;
    int total  = 0;
    int m_rf [NREG];
    int m_count = 0;

    function automatic int ref_alu(input int op, input int a, input int b);
        case (op)
            0:       return (a + b) % 16;
            1:       return (a - b + 16) % 16;
            2:       return a & b;
            3:       return a | b;
            4:       return 15 - a;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) m_rf[i] = 0;
        m_count = 0;
    endtask

    // Drive random command traffic while the sequencer is busy.
    task automatic garble();
        cmd_valid  = 1'b1;
        cmd_op     = 3'($urandom_range(7, 0));
        cmd_srca   = RW'($urandom_range(NREG - 1, 0));
        cmd_srcb   = RW'($urandom_range(NREG - 1, 0));
        cmd_dst    = RW'($urandom_range(NREG - 1, 0));
        cmd_imm_en = 1'($urandom_range(1, 0));
        cmd_imm    = 4'($urandom_range(15, 0));
    endtask

    task automatic do_cmd(input int op, input int sa, input int sb, input int d,
                          input bit ie, input int imm, input int hold, output int obs);
        int a, b, r, waited;
        waited = 0;
        obs = -1;
        while (!cmd_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        check("ready_wait", cmd_ready, 1);
        cmd_valid  = 1'b1;
        cmd_op     = op[2:0];
        cmd_srca   = sa[RW-1:0];
        cmd_srcb   = sb[RW-1:0];
        cmd_dst    = d[RW-1:0];
        cmd_imm_en = ie;
        cmd_imm    = imm[3:0];
        res_ready  = (hold == 0);
        a = m_rf[sa];
        b = ie ? imm : m_rf[sb];
        r = ref_alu(op, a, b);
        @(posedge clk); #1;
        garble();
        check("exec_valid", res_valid, 0);
        check("exec_ready", cmd_ready, 0);
        @(posedge clk); #1;
        obs = int'(res_data);
        check("res_valid", res_valid, 1);
        check("res_data", res_data, r);
        check("res_dst", res_dst, d);
        check("res_zero", res_zero, (r == 0));
        m_rf[d] = r;
        for (int i = 0; i < hold; i++) begin
            garble();
            @(posedge clk); #1;
            check("bp_valid", res_valid, 1);
            check("bp_data", res_data, r);
            check("bp_ready", cmd_ready, 0);
            check("bp_count", op_count, m_count);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        m_count = (m_count + 1) % (1 << CNT_W);
        check("done_ready", cmd_ready, 1);
        check("done_valid", res_valid, 0);
        check("op_count", op_count, m_count);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int obs;
        int exp_t [4];
        exp_t = '{12, 8, 0, 0};
        model_reset();

        // Power-on reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", res_valid, 0);
        check("rst_ready", cmd_ready, 1);
        check("rst_count", op_count, 0);
        check("rst_zero", res_zero, 1);
        check("rst_data", res_data, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ready", cmd_ready, 1);

        // Load via OR with immediate, then add wrapping to zero
        do_cmd(3, 0, 0, 1, 1'b1, 7, 0, obs);
        check("load7", obs, 7);
        do_cmd(0, 1, 0, 2, 1'b1, 9, 0, obs);
        check("wrap16", obs, 0);
        check("wrap16_zero", res_zero, 1);
        check("wrap16_dst", res_dst, 2);
        check("cnt_two", op_count, 2);

        // Subtract with borrow, NOT, and an unused opcode
        do_cmd(3, 0, 0, 1, 1'b1, 3, 0, obs);
        do_cmd(1, 1, 0, 3, 1'b1, 5, 0, obs);
        check("sub_borrow", obs, 14);
        do_cmd(4, 1, 0, 2, 1'b0, 0, 0, obs);
        check("not3", obs, 12);
        do_cmd(6, 1, 2, 3, 1'b0, 0, 0, obs);
        check("op110", obs, 0);
        do_cmd(3, 3, 0, 0, 1'b1, 0, 0, obs);
        check("rf3_cleared", obs, 0);

        // Backpressure for five cycles
        do_cmd(0, 1, 0, 2, 1'b1, 1, 5, obs);
        check("bp_result", obs, 4);

        // Aliased add at full throughput
        do_cmd(3, 0, 0, 1, 1'b1, 6, 0, obs);
        for (int i = 0; i < 4; i++) begin
            do_cmd(0, 1, 1, 1, 1'b0, 0, 0, obs);
            check("alias_seq", obs, exp_t[i]);
        end

        // Reset while a command is executing
        do_cmd(3, 0, 0, 1, 1'b1, 5, 0, obs);
        cmd_valid  = 1'b1;
        cmd_op     = 3'b000;
        cmd_srca   = 2'd1;
        cmd_dst    = 2'd2;
        cmd_imm_en = 1'b1;
        cmd_imm    = 4'd3;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("pre_rst_exec", cmd_ready, 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", res_valid, 0);
        check("mid_rst_ready", cmd_ready, 1);
        check("mid_rst_count", op_count, 0);
        check("mid_rst_zero", res_zero, 1);
        check("mid_rst_data", res_data, 0);
        check("mid_rst_dst", res_dst, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_ready", cmd_ready, 1);
        check("rel_valid", res_valid, 0);
        for (int i = 0; i < NREG; i++) begin
            do_cmd(3, i, 0, i, 1'b1, 0, 0, obs);
            check("rf_clear", obs, 0);
        end

        // Randomized traffic until the counter wraps back to zero
        for (int n = 0; n < 300 && m_count != 0; n++) begin
            do_cmd($urandom_range(7, 0), $urandom_range(NREG - 1, 0),
                   $urandom_range(NREG - 1, 0), $urandom_range(NREG - 1, 0),
                   1'($urandom_range(1, 0)), $urandom_range(15, 0),
                   $urandom_range(2, 0), obs);
        end
        check("count_wrap", op_count, 0);

        for (int n = 0; n < 10; n++) begin
            do_cmd($urandom_range(7, 0), $urandom_range(NREG - 1, 0),
                   $urandom_range(NREG - 1, 0), $urandom_range(NREG - 1, 0),
                   1'($urandom_range(1, 0)), $urandom_range(15, 0),
                   $urandom_range(2, 0), obs);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
